// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the sync_fifo drain side.
// Provides the default data width, a data word type and the 2-bit
// occupancy type used by the output skid buffer.
package fifo_pkg;

   localparam int WIDTH = 8;

   typedef logic [WIDTH-1:0] word_t;
   typedef logic [1:0]       occ_t;

endpackage

// File: rtl/fifo_stream_reader_chk.sv
// fifo_stream_reader_chk: run-time checks for the drain engine.
// Ports (all inputs): clk, rst_n, cnt (buffer occupancy), inflight,
// pop, fifo_r_en, fifo_empty.
module fifo_stream_reader_chk
   import fifo_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  occ_t cnt,
   input  logic inflight,
   input  logic pop,
   input  logic fifo_r_en,
   input  logic fifo_empty
);

   // Buffer must never overflow and reads must never target an empty FIFO.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(cnt == 2'd2 && inflight && !pop));
         assert (cnt != 2'd3);
         assert (!(fifo_r_en && fifo_empty));
      end
   end

endmodule

// File: rtl/skid_buf2.sv
// skid_buf2: 2-entry circular buffer that absorbs the FIFO read latency.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write push_data at the tail this edge
//   push_data   - word to store
//   pop         - release the head entry this edge (caller guarantees cnt != 0)
//   cnt         - current occupancy, 0..2
//   head_data   - word at the head pointer
module skid_buf2
   import fifo_pkg::*;
#(
   parameter int WIDTH = fifo_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output occ_t             cnt,
   output logic [WIDTH-1:0] head_data
);

   logic [WIDTH-1:0] mem [2];
   logic             head;
   logic             tail;

   // Storage, pointers and occupancy. When full, a push may coincide with a
   // pop: the tail then equals the head, and the outgoing word has already
   // been presented for the whole cycle, so overwriting it at the edge is safe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         head   <= 1'b0;
         tail   <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push) begin
            mem[tail] <= push_data;
            tail      <= ~tail;
         end
         if (pop) begin
            head <= ~head;
         end
         cnt <= occ_t'(cnt + {1'b0, push} - {1'b0, pop});
      end
   end

   assign head_data = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pulls words from a sync_fifo read port and presents
// them on a valid/ready stream, framed into bursts of BURST_LEN words.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   enable      - allow new FIFO reads (buffered/in-flight words still drain)
//   fifo_empty  - FIFO empty flag
//   fifo_dout   - FIFO registered read data (valid the cycle after a read)
//   fifo_r_en   - FIFO read request
//   m_valid, m_ready, m_data, m_last - output stream
//   rd_count    - words accepted downstream since reset (wraps)
//   busy        - a word is in flight or buffered
module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int WIDTH     = fifo_pkg::WIDTH,
   parameter int BURST_LEN = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_dout,
   output logic             fifo_r_en,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last,
   output logic [CNT_W-1:0] rd_count,
   output logic             busy
);

   localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

   occ_t        cnt;
   logic        inflight;
   logic        pop;
   logic [2:0]  pending;
   logic [15:0] bcnt;

   assign pop     = m_valid && m_ready;
   // Words already committed to the buffer: stored plus the one in flight.
   assign pending = {1'b0, cnt} + {2'b00, inflight};

   // Read issue: keep buffer plus in-flight within two slots, allowing a
   // read at two only when a word leaves this same cycle. Held low in reset.
   always_comb begin
      fifo_r_en = 1'b0;
      if (rst_n && enable && !fifo_empty) begin
         if (pending < 3'd2) begin
            fifo_r_en = 1'b1;
         end else if (pending == 3'd2 && pop) begin
            fifo_r_en = 1'b1;
         end else begin
            fifo_r_en = 1'b0;
         end
      end else begin
         fifo_r_en = 1'b0;
      end
   end

   skid_buf2 #(.WIDTH(WIDTH)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight),
      .push_data (fifo_dout),
      .pop       (pop),
      .cnt       (cnt),
      .head_data (m_data)
   );

   // In-flight flag, burst position and delivered-word counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= 1'b0;
         bcnt     <= 16'd0;
         rd_count <= '0;
      end else begin
         inflight <= fifo_r_en;
         if (pop) begin
            rd_count <= rd_count + {{(CNT_W-1){1'b0}}, 1'b1};
            if (bcnt == LAST_IDX) begin
               bcnt <= 16'd0;
            end else begin
               bcnt <= bcnt + 16'd1;
            end
         end
      end
   end

   assign m_valid = (cnt != 2'd0);
   assign m_last  = m_valid && (bcnt == LAST_IDX);
   assign busy    = m_valid || inflight;

   fifo_stream_reader_chk u_chk (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt        (cnt),
      .inflight   (inflight),
      .pop        (pop),
      .fifo_r_en  (fifo_r_en),
      .fifo_empty (fifo_empty)
   );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader with a queue-based FIFO model
// and a scoreboard of words in write order.
module tb_fifo_stream_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        fifo_empty = 1'b1;
   logic [7:0]  fifo_dout = 8'h00;
   logic        fifo_r_en;
   logic        m_valid;
   logic        m_ready;
   logic [7:0]  m_data;
   logic        m_last;
   logic [15:0] rd_count;
   logic        busy;

   fifo_stream_reader #(.WIDTH(8), .BURST_LEN(4), .CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_r_en  (fifo_r_en),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .rd_count   (rd_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   logic [7:0] wq[$];     // writes waiting to enter the FIFO
   logic [7:0] fq[$];     // FIFO contents
   logic [7:0] exp_q[$];  // expected output order
   logic [8:0] obs_q[$];  // observed {last, data} per accepted word

   int reads = 0;
   int outstanding = 0;
   int viol_empty = 0;
   int viol_occ = 0;
   int viol_stab = 0;
   logic       hold_p = 1'b0;
   logic [7:0] hold_d = 8'h00;
   logic       hold_l = 1'b0;

   // FIFO model plus stream monitor; samples pre-edge values at each edge.
   always @(posedge clk) begin
      automatic int o = outstanding;
      if (!rst_n) begin
         o = 0;
         hold_p <= 1'b0;
      end else begin
         if (fifo_r_en) begin
            reads <= reads + 1;
            o = o + 1;
            if (fq.size() == 0) viol_empty <= viol_empty + 1;
            else fifo_dout <= fq.pop_front();
         end
         if (m_valid && m_ready) begin
            obs_q.push_back({m_last, m_data});
            o = o - 1;
         end
         if (o > 2) viol_occ <= viol_occ + 1;
         if (hold_p && !(m_valid && m_data === hold_d && m_last === hold_l))
            viol_stab <= viol_stab + 1;
         hold_p <= m_valid && !m_ready;
         hold_d <= m_data;
         hold_l <= m_last;
      end
      outstanding <= o;
      while (wq.size() > 0) fq.push_back(wq.pop_front());
      fifo_empty <= (fq.size() == 0);
   end

   int total = 0;
   int bad = 0;
   int bpos = 0;
   int exp_rd = 0;
   int rd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] d);
      wq.push_back(d);
      exp_q.push_back(d);
   endtask

   // Compare every observed word against the write-order model and burst position.
   task automatic drain(input string tag, input int n);
      logic [8:0] o;
      logic [7:0] e;
      chk({tag, " count"}, obs_q.size(), n);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         chk({tag, " data"}, {24'd0, o[7:0]}, {24'd0, e});
         chk({tag, " last"}, {31'd0, o[8]}, (bpos == 3) ? 32'd1 : 32'd0);
         bpos = (bpos + 1) % 4;
         exp_rd++;
      end
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0;
      repeat (2) cyc();
      chk("rst m_valid", m_valid, 0);
      chk("rst m_data", m_data, 0);
      chk("rst m_last", m_last, 0);
      chk("rst rd_count", rd_count, 0);
      chk("rst busy", busy, 0);
      chk("rst r_en", fifo_r_en, 0);
      rst_n = 1'b1;
      cyc();

      // Straight stream with latency check.
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) wr(8'(8'h10 + i));
      repeat (2) cyc();
      enable = 1'b1;
      #1;
      chk("t1 r_en first", fifo_r_en, 1);
      chk("t1 valid early", m_valid, 0);
      cyc();
      chk("t1 valid +1", m_valid, 0);
      cyc();
      chk("t1 valid +2", m_valid, 1);
      chk("t1 first data", m_data, 32'h10);
      repeat (8) cyc();
      drain("t1", 8);
      chk("t1 rd_count", rd_count, 32'(exp_rd));
      chk("t1 busy", busy, 0);

      // Back-pressure: only two reads, head word held.
      enable = 1'b0; m_ready = 1'b0;
      for (int i = 0; i < 8; i++) wr(8'(8'h10 + i));
      repeat (2) cyc();
      rd0 = reads;
      enable = 1'b1;
      repeat (10) cyc();
      chk("t2 reads", reads - rd0, 2);
      chk("t2 r_en", fifo_r_en, 0);
      chk("t2 valid", m_valid, 1);
      chk("t2 held data", m_data, 32'h10);
      m_ready = 1'b1;
      repeat (10) cyc();
      drain("t2", 8);

      // Random ready with a concurrent writer.
      begin
         int nw = 0;
         for (int i = 0; i < 3000 && obs_q.size() < 64; i++) begin
            if (nw < 64 && $urandom_range(0, 1) == 1) begin
               wr(8'($urandom));
               nw++;
            end
            m_ready = ($urandom_range(0, 1) == 1);
            cyc();
         end
      end
      m_ready = 1'b1;
      repeat (4) cyc();
      drain("t3", 64);
      chk("t3 rd_count", rd_count, 32'(exp_rd));

      // FIFO runs dry mid-burst; burst resumes later.
      wr(8'hA0); wr(8'hA1);
      repeat (8) cyc();
      drain("t4a", 2);
      chk("t4 valid idle", m_valid, 0);
      chk("t4 busy idle", busy, 0);
      wr(8'hA2); wr(8'hA3);
      repeat (8) cyc();
      drain("t4b", 2);

      // enable dropped right after a read is issued.
      wr(8'hB0); wr(8'hB1);
      cyc();
      chk("t5 r_en", fifo_r_en, 1);
      rd0 = reads;
      cyc();
      enable = 1'b0;
      #1;
      chk("t5 r_en off", fifo_r_en, 0);
      chk("t5 busy", busy, 1);
      repeat (6) cyc();
      chk("t5 reads", reads - rd0, 1);
      drain("t5", 1);
      chk("t5 busy end", busy, 0);
      chk("t5 rd_count", rd_count, 32'(exp_rd));

      // Asynchronous reset with two words buffered.
      for (int i = 0; i < 4; i++) wr(8'(8'hC0 + i));
      m_ready = 1'b0; enable = 1'b1;
      repeat (6) cyc();
      chk("t6 valid", m_valid, 1);
      chk("t6 data", m_data, 32'hB1);
      chk("t6 busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6 rst valid", m_valid, 0);
      chk("t6 rst data", m_data, 0);
      chk("t6 rst last", m_last, 0);
      chk("t6 rst rd_count", rd_count, 0);
      chk("t6 rst busy", busy, 0);
      chk("t6 rst r_en", fifo_r_en, 0);
      chk("t6 obs empty", obs_q.size(), 0);
      exp_q = fq;
      bpos = 0;
      exp_rd = 0;
      repeat (2) cyc();
      rst_n = 1'b1;
      m_ready = 1'b1;
      repeat (8) cyc();
      drain("t6", 3);
      chk("t6 rd_count", rd_count, 32'(exp_rd));
      chk("t6 busy end", busy, 0);

      chk("read while empty", viol_empty, 0);
      chk("occupancy over 2", viol_occ, 0);
      chk("output stability", viol_stab, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
